// File: rtl/sum_bcd_display_if.sv
// Handshake and display bus between the adder stage and the BCD display converter.
// The slave side is the converter; the master side drives sums and watches the results.
interface sum_bcd_display_if #(
  parameter int IN_W   = 5,
  parameter int DIGITS = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic [IN_W-1:0]       sum_in;
  logic                  out_valid;
  logic                  busy;
  logic [4*DIGITS-1:0]   bcd_out;
  logic [7*DIGITS-1:0]   seg_out;

  modport master (
    output in_valid, sum_in,
    input  in_ready, out_valid, busy, bcd_out, seg_out
  );

  modport slave (
    input  in_valid, sum_in,
    output in_ready, out_valid, busy, bcd_out, seg_out
  );
endinterface

// File: rtl/sum_bcd_display.sv
// Captures the adder sum, converts it to packed BCD with a bit-serial double-dabble FSM,
// and registers the BCD digits plus their 7-segment patterns for the board display.
module sum_bcd_display #(
  parameter int IN_W     = 5,
  parameter int DIGITS   = 2,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  sum_bcd_display_if.slave bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SEG_W = 7 * DIGITS;
  localparam int SH_W  = BCD_W + IN_W;
  localparam int CNT_W = $clog2(IN_W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SH_W-1:0]    r_shift;
  logic [SH_W-1:0]    w_shift_nxt;
  logic [SH_W-1:0]    w_adj;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [BCD_W-1:0]   r_bcd;
  logic [BCD_W-1:0]   w_bcd_nxt;
  logic [SEG_W-1:0]   r_seg;
  logic [SEG_W-1:0]   w_seg_nxt;
  logic [SEG_W-1:0]   w_seg_dec;
  logic               r_out_valid;
  logic               w_out_valid_nxt;
  logic               r_in_ready;
  logic               r_busy;

  // Segment order {g,f,e,d,c,b,a}; non-decimal codes light nothing.
  function automatic logic [6:0] f_seg7(input logic [3:0] i_digit);
    logic [6:0] v_seg;
    case (i_digit)
      4'd0:    v_seg = 7'b0111111;
      4'd1:    v_seg = 7'b0000110;
      4'd2:    v_seg = 7'b1011011;
      4'd3:    v_seg = 7'b1001111;
      4'd4:    v_seg = 7'b1100110;
      4'd5:    v_seg = 7'b1101101;
      4'd6:    v_seg = 7'b1111101;
      4'd7:    v_seg = 7'b0000111;
      4'd8:    v_seg = 7'b1111111;
      4'd9:    v_seg = 7'b1101111;
      default: v_seg = 7'b0000000;
    endcase
    return v_seg;
  endfunction

  // Add-3 correction on every BCD digit, all judged on pre-adjust values.
  always_comb begin
    w_adj = r_shift;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_shift[IN_W+4*k +: 4] >= 4'd5) begin
        w_adj[IN_W+4*k +: 4] = r_shift[IN_W+4*k +: 4] + 4'd3;
      end else begin
        w_adj[IN_W+4*k +: 4] = r_shift[IN_W+4*k +: 4];
      end
    end
  end

  // Decode the finished BCD field, blanking leading zeros above the ones digit.
  always_comb begin : seg_decode
    logic       v_lead;
    logic [3:0] v_digit;
    w_seg_dec = '0;
    v_lead    = 1'b1;
    v_digit   = 4'd0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      v_digit = r_shift[IN_W+4*k +: 4];
      if (v_digit != 4'd0) begin
        v_lead = 1'b0;
      end else begin
        v_lead = v_lead;
      end
      if (BLANK_LZ && v_lead && (k != 0)) begin
        w_seg_dec[7*k +: 7] = 7'b0000000;
      end else begin
        w_seg_dec[7*k +: 7] = f_seg7(v_digit);
      end
    end
  end

  // Next-state and datapath selection for the conversion FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_count_nxt     = r_count;
    w_bcd_nxt       = r_bcd;
    w_seg_nxt       = r_seg;
    w_out_valid_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_state_nxt = S_CONV;
          w_shift_nxt = {{BCD_W{1'b0}}, bus.sum_in};
          w_count_nxt = CNT_W'(IN_W);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CONV: begin
        w_shift_nxt = w_adj << 1;
        w_count_nxt = r_count - CNT_W'(1);
        if (r_count == CNT_W'(1)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_CONV;
        end
      end
      S_DONE: begin
        w_state_nxt     = S_IDLE;
        w_bcd_nxt       = r_shift[SH_W-1:IN_W];
        w_seg_nxt       = w_seg_dec;
        w_out_valid_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers; handshake flags follow the next state so they are registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_count     <= '0;
      r_bcd       <= '0;
      r_seg       <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_count     <= w_count_nxt;
      r_bcd       <= w_bcd_nxt;
      r_seg       <= w_seg_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_busy      <= (w_state_nxt == S_CONV);
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.busy      = r_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.bcd_out   = r_bcd;
  assign bus.seg_out   = r_seg;

endmodule

// File: tb/tb_sum_bcd_display.sv
// Self-checking bench: two converters (leading-zero blanking on and off) fed the same sums,
// compared against a decimal-arithmetic reference model.
module tb_sum_bcd_display;
  localparam int IN_W   = 5;
  localparam int DIGITS = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sum_bcd_display_if #(.IN_W(IN_W), .DIGITS(DIGITS)) bus0 ();
  sum_bcd_display_if #(.IN_W(IN_W), .DIGITS(DIGITS)) bus1 ();
  assign bus1.in_valid = bus0.in_valid;
  assign bus1.sum_in   = bus0.sum_in;

  sum_bcd_display #(.IN_W(IN_W), .DIGITS(DIGITS), .BLANK_LZ(1'b1)) dut_blank (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  sum_bcd_display #(.IN_W(IN_W), .DIGITS(DIGITS), .BLANK_LZ(1'b0)) dut_noblank (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  int n_checks = 0;
  int n_pass   = 0;

  logic [6:0] seg_tbl [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  logic [7:0]  prev_bcd;
  logic [13:0] prev_seg0;
  logic [13:0] prev_seg1;

  function automatic logic [7:0] exp_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [13:0] exp_seg(input int v, input bit blank);
    logic [6:0] hi;
    hi = (blank && (v / 10 == 0)) ? 7'b0000000 : seg_tbl[v / 10];
    return {hi, seg_tbl[v % 10]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus0.in_ready && n < 20) begin
      tick();
      n++;
    end
    n_checks++;
    if (bus0.in_ready !== 1'b1) $display("FAIL %s wait_ready got %b want 1", name, bus0.in_ready);
    else n_pass++;
  endtask

  // Accept v, follow it to out_valid, and check timing, hold behaviour and results.
  task automatic do_conv(input int v, input string name);
    int edges;
    wait_ready(name);
    bus0.in_valid = 1'b1;
    bus0.sum_in   = 5'(v);
    tick();
    edges = 1;
    bus0.in_valid = 1'b0;
    n_checks++;
    if (bus0.busy !== 1'b1) $display("FAIL %s accept busy got %b want 1", name, bus0.busy);
    else n_pass++;
    while (!bus0.out_valid && edges < 20) begin
      n_checks++;
      if (bus0.bcd_out !== prev_bcd || bus0.seg_out !== prev_seg0 || bus1.seg_out !== prev_seg1)
        $display("FAIL %s hold got %h/%h/%h want %h/%h/%h", name, bus0.bcd_out, bus0.seg_out,
                 bus1.seg_out, prev_bcd, prev_seg0, prev_seg1);
      else n_pass++;
      tick();
      edges++;
    end
    n_checks++;
    if (edges !== 7) $display("FAIL %s latency got %0d edges want 7", name, edges);
    else n_pass++;
    n_checks++;
    if (bus0.bcd_out !== exp_bcd(v)) $display("FAIL %s bcd got %h want %h", name, bus0.bcd_out, exp_bcd(v));
    else n_pass++;
    n_checks++;
    if (bus0.seg_out !== exp_seg(v, 1'b1))
      $display("FAIL %s seg_blank got %b want %b", name, bus0.seg_out, exp_seg(v, 1'b1));
    else n_pass++;
    n_checks++;
    if (bus1.seg_out !== exp_seg(v, 1'b0) || bus1.bcd_out !== exp_bcd(v))
      $display("FAIL %s seg_noblank got %b want %b", name, bus1.seg_out, exp_seg(v, 1'b0));
    else n_pass++;
    n_checks++;
    if (bus0.in_ready !== 1'b1 || bus0.busy !== 1'b0)
      $display("FAIL %s ready_at_valid got %b%b want 10", name, bus0.in_ready, bus0.busy);
    else n_pass++;
    prev_bcd  = exp_bcd(v);
    prev_seg0 = exp_seg(v, 1'b1);
    prev_seg1 = exp_seg(v, 1'b0);
    tick();
    n_checks++;
    if (bus0.out_valid !== 1'b0) $display("FAIL %s pulse_width got %b want 0", name, bus0.out_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    n_checks++;
    if ({bus0.in_ready, bus0.busy, bus0.out_valid} !== 3'b100)
      $display("FAIL reset flags got %b want 100", {bus0.in_ready, bus0.busy, bus0.out_valid});
    else n_pass++;
    n_checks++;
    if (bus0.bcd_out !== 8'h00 || bus0.seg_out !== 14'h0000 || bus1.seg_out !== 14'h0000)
      $display("FAIL reset outputs got %h/%h/%h want 00/0000/0000", bus0.bcd_out, bus0.seg_out, bus1.seg_out);
    else n_pass++;
    prev_bcd  = 8'h00;
    prev_seg0 = 14'h0000;
    prev_seg1 = 14'h0000;
  endtask

  task automatic test_fixed();
    do_conv(30, "sum30");
    do_conv(0, "sum0");
    do_conv(10, "sum10");
    do_conv(9, "sum9");
  endtask

  task automatic test_back_to_back();
    int edges;
    wait_ready("b2b");
    bus0.in_valid = 1'b1;
    bus0.sum_in   = 5'd19;
    tick();
    edges = 1;
    while (!bus0.out_valid && edges < 20) begin
      tick();
      edges++;
    end
    n_checks++;
    if (edges !== 7 || bus0.bcd_out !== 8'h19 || bus0.seg_out !== {7'b0000110, 7'b1101111})
      $display("FAIL b2b_first got %0d/%h/%b want 7/19/%b", edges, bus0.bcd_out, bus0.seg_out,
               {7'b0000110, 7'b1101111});
    else n_pass++;
    bus0.sum_in = 5'd7;
    tick();
    edges = 1;
    n_checks++;
    if (bus0.busy !== 1'b1) $display("FAIL b2b_second_accept busy got %b want 1", bus0.busy);
    else n_pass++;
    bus0.in_valid = 1'b0;
    while (!bus0.out_valid && edges < 20) begin
      tick();
      edges++;
    end
    n_checks++;
    if (edges !== 7 || bus0.bcd_out !== 8'h07 || bus0.seg_out !== {7'b0000000, 7'b0000111})
      $display("FAIL b2b_second got %0d/%h/%b want 7/07/%b", edges, bus0.bcd_out, bus0.seg_out,
               {7'b0000000, 7'b0000111});
    else n_pass++;
    prev_bcd  = exp_bcd(7);
    prev_seg0 = exp_seg(7, 1'b1);
    prev_seg1 = exp_seg(7, 1'b0);
  endtask

  task automatic test_ignore();
    int edges;
    wait_ready("ignore");
    bus0.in_valid = 1'b1;
    bus0.sum_in   = 5'd9;
    tick();
    bus0.in_valid = 1'b0;
    tick();
    edges = 2;
    bus0.in_valid = 1'b1;
    bus0.sum_in   = 5'd25;
    while (!bus0.out_valid && edges < 20) begin
      n_checks++;
      if (bus0.in_ready !== 1'b0) $display("FAIL ignore_ready got %b want 0 at edge %0d", bus0.in_ready, edges);
      else n_pass++;
      tick();
      edges++;
    end
    bus0.in_valid = 1'b0;
    n_checks++;
    if (edges !== 7 || bus0.bcd_out !== 8'h09 || bus0.seg_out !== exp_seg(9, 1'b1))
      $display("FAIL ignore_result got %0d/%h want 7/09", edges, bus0.bcd_out);
    else n_pass++;
    prev_bcd  = exp_bcd(9);
    prev_seg0 = exp_seg(9, 1'b1);
    prev_seg1 = exp_seg(9, 1'b0);
    tick();
    n_checks++;
    if (bus0.busy !== 1'b0 || bus0.in_ready !== 1'b1)
      $display("FAIL ignore_idle got busy=%b ready=%b want 0/1", bus0.busy, bus0.in_ready);
    else n_pass++;
  endtask

  task automatic test_midreset();
    int seen = 0;
    wait_ready("midreset");
    bus0.in_valid = 1'b1;
    bus0.sum_in   = 5'd30;
    tick();
    bus0.in_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if ({bus0.in_ready, bus0.busy, bus0.out_valid} !== 3'b100 || bus0.bcd_out !== 8'h00 ||
        bus0.seg_out !== 14'h0000)
      $display("FAIL midreset_state got %b/%h/%h want 100/00/0000",
               {bus0.in_ready, bus0.busy, bus0.out_valid}, bus0.bcd_out, bus0.seg_out);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      if (bus0.out_valid) seen++;
      tick();
    end
    n_checks++;
    if (seen !== 0) $display("FAIL midreset_no_pulse got %0d pulses want 0", seen);
    else n_pass++;
    prev_bcd  = 8'h00;
    prev_seg0 = 14'h0000;
    prev_seg1 = 14'h0000;
    do_conv(12, "after_reset12");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      do_conv(int'($urandom_range(0, 30)), "random");
    end
  endtask

  initial begin
    bus0.in_valid = 1'b0;
    bus0.sum_in   = 5'd0;
    test_reset();
    test_fixed();
    test_back_to_back();
    test_ignore();
    test_midreset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
